// File: rtl/uart_cmd_sequencer.sv
// UART "#<chan><mode>\n" command parser driving NUM_LED on/off/blink channels.
// Optional CMD_ECHO_EN adds a 'K'/'E' acknowledge byte on a valid/ready tx port.

// One LED channel. Mode encoding: 00 off, 01 on, 10 blink.
module uart_led_chan (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [1:0] wmode,
  input  logic       phase_nxt,
  output logic       led
);
  logic [1:0] mode_q, mode_d;
  logic       led_q, led_d;

  always_comb begin
    mode_d = we ? wmode : mode_q;
    // Driven from next-state values so a commit shows on leds one cycle after the LF.
    led_d  = mode_d[1] ? phase_nxt : mode_d[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 2'b00;
      led_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      led_q  <= led_d;
    end
  end

  assign led = led_q;
endmodule

module uart_cmd_sequencer #(
  parameter int NUM_LED   = 4,
  parameter int BLINK_DIV = 6000000,
  parameter int TIMEOUT   = 1200000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         data,
  input  logic               data_valid,
  output logic [NUM_LED-1:0] leds,
  output logic               frame_err,
  output logic [7:0]         err_cnt
`ifdef CMD_ECHO_EN
  ,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready
`endif
);
  localparam int CW = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
  localparam int BW = $clog2(BLINK_DIV);
  localparam int GW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_CHAN, S_MODE, S_TERM} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] chan_q, chan_d;
  logic [1:0]    mode_q, mode_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic          ferr_q, ferr_d;
  logic [7:0]    ecnt_q, ecnt_d;
  logic          err, commit, dig_ok;

  assign dig_ok = (data >= 8'h30) && ((data - 8'h30) < 8'(NUM_LED));

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    mode_d  = mode_q;
    gap_d   = gap_q;
    err     = 1'b0;
    commit  = 1'b0;
    if (state_q != S_IDLE) gap_d = gap_q + 1'b1;
    if (data_valid) begin
      // An accepted byte always wins over a coincident timeout.
      gap_d = '0;
      case (state_q)
        S_IDLE: if (data == 8'h23) state_d = S_CHAN;
        S_CHAN: begin
          if (dig_ok) begin
            chan_d  = CW'(data - 8'h30);
            state_d = S_MODE;
          end else begin
            err     = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_MODE: begin
          state_d = S_TERM;
          case (data)
            8'h4F:   mode_d = 2'b01;
            8'h46:   mode_d = 2'b00;
            8'h42:   mode_d = 2'b10;
            default: begin
              err     = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
        S_TERM: begin
          if (data == 8'h0A) commit = 1'b1;
          else               err    = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && gap_q == GW'(TIMEOUT - 2)) begin
      // Counter reaches TIMEOUT-1 on this edge: abandon the frame.
      err     = 1'b1;
      state_d = S_IDLE;
    end
    if (state_d == S_IDLE) gap_d = '0;

    ferr_d = err;
    ecnt_d = (err && ecnt_q != 8'hFF) ? ecnt_q + 8'd1 : ecnt_q;

    bcnt_d  = (bcnt_q == BW'(BLINK_DIV - 1)) ? '0 : bcnt_q + 1'b1;
    phase_d = (bcnt_q == BW'(BLINK_DIV - 1)) ? ~phase_q : phase_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      chan_q  <= '0;
      mode_q  <= 2'b00;
      gap_q   <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      ferr_q  <= 1'b0;
      ecnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      mode_q  <= mode_d;
      gap_q   <= gap_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      ferr_q  <= ferr_d;
      ecnt_q  <= ecnt_d;
    end
  end

  for (genvar i = 0; i < NUM_LED; i++) begin : g_chan
    uart_led_chan u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (commit && (chan_q == CW'(i))),
      .wmode     (mode_q),
      .phase_nxt (phase_d),
      .led       (leds[i])
    );
  end

  assign frame_err = ferr_q;
  assign err_cnt   = ecnt_q;

`ifdef CMD_ECHO_EN
  logic [7:0] txd_q, txd_d;
  logic       txv_q, txv_d;

  always_comb begin
    txd_d = txd_q;
    txv_d = txv_q;
    if (txv_q && tx_ready) txv_d = 1'b0;
    // A slot freed by a handshake this cycle can take the new ack; otherwise it is dropped.
    if ((commit || err) && (!txv_q || tx_ready)) begin
      txv_d = 1'b1;
      txd_d = commit ? 8'h4B : 8'h45;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txd_q <= 8'h00;
      txv_q <= 1'b0;
    end else begin
      txd_q <= txd_d;
      txv_q <= txv_d;
    end
  end

  assign tx_data  = txd_q;
  assign tx_valid = txv_q;
`endif
endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Scoreboard bench for uart_cmd_sequencer (NUM_LED=4, BLINK_DIV=4, TIMEOUT=8).
module tb_uart_cmd_sequencer;
  localparam int NL = 4;
  localparam int BD = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    data = 8'h00;
  logic          data_valid = 1'b0;
  logic [NL-1:0] leds;
  logic          frame_err;
  logic [7:0]    err_cnt;
`ifdef CMD_ECHO_EN
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
`endif

  uart_cmd_sequencer #(.NUM_LED(NL), .BLINK_DIV(BD), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .data_valid (data_valid),
    .leds       (leds),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt)
`ifdef CMD_ECHO_EN
    ,
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
`endif
  );

  always #5 clk = ~clk;

  // kind 0: frame_err pulse expected; kind 1: leds check on the next LF strobe
  typedef struct {
    int         kind;
    logic [7:0] cnt;
    int         cyc;
    logic [3:0] led_exp;
    logic [3:0] bmask;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_errs = 0;
  bit   lf_seen = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    lf_seen <= rst_n && data_valid && (data == 8'h0A);
  end

  always @(negedge clk) begin
    exp_t e;
    if (frame_err) begin
      checks++;
      if (q.size() == 0 || q[0].kind != 0) begin
        errors++;
        $display("FAIL unexpected_frame_err got=1 want=0 cyc=%0d", cyc);
      end else begin
        e = q.pop_front();
        if (err_cnt !== e.cnt) begin
          errors++;
          $display("FAIL err_cnt got=%0d want=%0d", err_cnt, e.cnt);
        end
        if (e.cyc >= 0) begin
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL timeout_cycle got=%0d want=%0d", cyc, e.cyc);
          end
        end
      end
    end
    if (lf_seen && q.size() > 0 && q[0].kind == 1) begin
      e = q.pop_front();
      checks++;
      if ((leds & ~e.bmask) !== (e.led_exp & ~e.bmask)) begin
        errors++;
        $display("FAIL leds_static got=%b want=%b mask=%b", leds, e.led_exp, ~e.bmask);
      end
      checks++;
      if ((leds & e.bmask) != 4'b0 && (leds & e.bmask) != e.bmask) begin
        errors++;
        $display("FAIL blink_in_phase got=%b want all-equal under %b", leds, e.bmask);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic push_err(input int c);
    exp_t e;
    exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
    e = '{0, 8'(exp_errs), c, 4'b0, 4'b0};
    q.push_back(e);
  endtask

  task automatic push_led(input logic [3:0] v, input logic [3:0] m);
    exp_t e;
    e = '{1, 8'h00, -1, v, m};
    q.push_back(e);
  endtask

  // Called at a negedge; returns at a negedge after exactly g idle sampling edges.
  task automatic send_byte(input logic [7:0] b, input int g);
    data       = b;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (g) @(negedge clk);
  endtask

  task automatic send_str(input string s, input int g);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], g);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int chg[$];
    logic prev;
    int mis;
    repeat (2) @(negedge clk);
    chk("rst_leds", 32'(leds), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Partial frame cut by reset: no commit, no error.
    send_str("#2", 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_leds", 32'(leds), 0);
    rst_n = 1'b1;
    @(negedge clk);
    push_led(4'b0000, 4'b0000);
    send_str("O\n", 0); idle(2);

    push_led(4'b0100, 4'b0000); send_str("#2O\n", 0); idle(2);
    push_led(4'b0100, 4'b1000); send_str("#3B\n", 0); idle(2);
    push_led(4'b0100, 4'b1010); send_str("#1B\n", 0); idle(2);

    // Blink period and phase of channels 1 and 3.
    mis  = 0;
    prev = leds[1];
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (leds[1] != leds[3]) mis++;
      if (leds[1] != prev) chg.push_back(i);
      prev = leds[1];
    end
    chk("blink_phase_match", 32'(mis), 0);
    chk("blink_toggles", 32'(chg.size() >= 5), 1);
    for (int i = 1; i < chg.size(); i++) chk("blink_period", 32'(chg[i] - chg[i-1]), BD);

    push_err(-1); push_led(4'b0100, 4'b1010); send_str("#7O\n", 0); idle(2);
    push_err(-1); push_led(4'b0100, 4'b1010); send_str("#2X\n", 0); idle(2);
    push_err(-1); push_led(4'b0100, 4'b1010); send_str("#2O#", 0); send_str("3F\n", 0); idle(2);

    // Idle after "#0": error 7 cycles after '0' is sampled.
    send_str("#0", 0);
    push_err(cyc + 7);
    idle(12);
    push_led(4'b0101, 4'b1010); send_str("#0O\n", 0); idle(2);
    push_led(4'b0100, 4'b1010); send_str("#0F\n", 0); idle(2);

    // Each byte lands on the very edge where the timeout would fire.
    push_led(4'b0101, 4'b1010);
    send_byte(8'h23, 6); send_byte(8'h30, 6); send_byte(8'h4F, 6); send_byte(8'h0A, 0);
    idle(2);

`ifdef CMD_ECHO_EN
    tx_ready = 1'b0;
`endif
    for (int i = 0; i < 256; i++) begin
      push_err(-1);
      send_str("#9", 0);
    end
    idle(4);
    chk("err_cnt_sat", 32'(err_cnt), 255);
    chk("leds_after_errs", 32'(leds & 4'b0101), 32'h5);
    chk("scoreboard_empty", 32'(q.size()), 0);
`ifdef CMD_ECHO_EN
    chk("tx_valid_held", 32'(tx_valid), 1);
    chk("tx_data_first_E", 32'(tx_data), 32'h45);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("tx_valid_cleared", 32'(tx_valid), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_cmd_sequencer.md
UART_CMD_SEQUENCER -- requirements
Module: uart_cmd_sequencer

Interface
REQ-001 Parameter NUM_LED, default 4, number of LED channels; legal range 1..10.
REQ-002 Parameter BLINK_DIV, default 6000000, clock cycles per blink half-period; minimum 2.
REQ-003 Parameter TIMEOUT, default 1200000, maximum idle cycles allowed between bytes of one frame; minimum 2.
REQ-004 clk  input  1  single system clock; all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 data  input  8  received UART byte, sampled only when data_valid=1.
REQ-007 data_valid  input  1  one-cycle strobe qualifying data.
REQ-008 leds  output  NUM_LED  LED drive, registered.
REQ-009 frame_err  output  1  one-cycle pulse on any rejected frame.
REQ-010 err_cnt  output  8  saturating count of rejected frames.
REQ-011 tx_data  output  8  acknowledge byte; present only with CMD_ECHO_EN.
REQ-012 tx_valid  output  1  acknowledge valid; present only with CMD_ECHO_EN.
REQ-013 tx_ready  input  1  downstream transmitter accepts tx_data; present only with CMD_ECHO_EN.

Function
REQ-014 Frame format SHALL be '#' (0x23), channel digit '0'+n with n < NUM_LED, mode byte, LF (0x0A).
REQ-015 Mode bytes SHALL be 'O' (0x4F) = on, 'F' (0x46) = off, 'B' (0x42) = blink.
REQ-016 Parser FSM SHALL have states IDLE, CHAN, MODE, TERM and advance at most one state per accepted byte.
REQ-017 IDLE: 0x23 -> CHAN; every other byte ignored, no error.
REQ-018 CHAN: valid digit -> latch channel, go to MODE; any other byte -> error, go to IDLE.
REQ-019 MODE: 'O'/'F'/'B' -> latch mode, go to TERM; any other byte -> error, go to IDLE.
REQ-020 TERM: 0x0A -> commit mode to the latched channel, go to IDLE; any other byte, including 0x23 -> error, go to IDLE.
REQ-021 Commit SHALL be written on the clock edge sampling the LF; the new leds value SHALL be visible from the next cycle onward.
REQ-022 Each channel SHALL hold a 2-bit mode register, reset to off; mode persists until overwritten by a later frame.
REQ-023 A single shared free-running counter SHALL toggle blink_phase when it reaches BLINK_DIV-1, then wrap to 0.
REQ-024 leds[i] SHALL be 1 for on, 0 for off, blink_phase for blink; all blinking channels SHALL be in phase, with no phase restart on commit.
REQ-025 Outside IDLE, a gap counter SHALL clear on every accepted byte; reaching TIMEOUT-1 SHALL cause an error and a return to IDLE.
REQ-026 If data_valid and timeout expiry coincide, the byte SHALL be processed and the timeout suppressed.
REQ-027 An error SHALL pulse frame_err for exactly one cycle and increment err_cnt, which saturates at 255.
REQ-028 Error handling SHALL NOT alter any channel mode register.

Reset
REQ-029 On rst_n=0, asynchronously: FSM to IDLE; leds, all modes, blink counter, blink_phase, gap counter, frame_err and err_cnt to 0; tx_valid to 0.
REQ-030 A partial frame interrupted by reset SHALL be discarded with no commit and no error.

Configuration
REQ-031 With CMD_ECHO_EN defined: each commit SHALL queue ack 'K' (0x4B) and each error SHALL queue ack 'E' (0x45) on tx_data, with tx_valid asserted the next cycle.
REQ-032 With CMD_ECHO_EN, tx_valid and tx_data SHALL hold until the cycle in which tx_valid and tx_ready are both 1; a new ack arriving while one is pending SHALL be dropped.
REQ-033 Without CMD_ECHO_EN: tx ports and ack logic absent; all other behaviour identical.

Verification
REQ-034 Bytes "#2O\n" -> leds[2]=1 one cycle after the LF; other leds unchanged; frame_err never asserted.
REQ-035 Bytes "#1B\n" with BLINK_DIV=4 -> leds[1] toggles every 4 cycles, in phase with a channel already set to blink.
REQ-036 Bytes "#7O\n" with NUM_LED=4 -> frame_err pulses on '7'; 'O' and LF are ignored; err_cnt=1; leds unchanged.
REQ-037 With TIMEOUT=8: send "#0" then stay idle -> frame_err pulses 7 cycles after '0'; next frame "#0F\n" is accepted.
REQ-038 256 bad frames -> err_cnt=255; CMD_ECHO_EN with tx_ready held 0 -> first 'E' held and later acks dropped.
